// File: rtl/tag_freelist_pkg.sv
// Shared definitions for the tag free list: default widths, tag type, clog2.
package tag_pkg;

   localparam int unsigned TAG_WIDTH_DEF = 5;
   localparam int unsigned RET_PORTS_DEF = 2;

   typedef logic [TAG_WIDTH_DEF-1:0] tag_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/tag_freelist_ret_compact.sv
// Packs valid retire-bus tags into consecutive write slots, bounded by the
// available space; anything past the limit is dropped, highest port first.
module tag_ret_compact
   import tag_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF,
   parameter int unsigned RET_PORTS = RET_PORTS_DEF,
   parameter int unsigned CNT_W     = 6
) (
   input  logic [RET_PORTS*TAG_WIDTH-1:0] RB_Tag,
   input  logic [RET_PORTS-1:0]           RB_Tag_Valid,
   input  logic [CNT_W-1:0]               space,
   output logic [RET_PORTS*TAG_WIDTH-1:0] slot_tag,
   output logic [RET_PORTS-1:0]           slot_we,
   output logic [CNT_W-1:0]               acc_cnt,
   output logic                           drop
);

   always_comb begin
      int unsigned k;
      slot_tag = '0;
      slot_we  = '0;
      drop     = 1'b0;
      k        = 0;
      for (int unsigned i = 0; i < RET_PORTS; i++) begin
         if (RB_Tag_Valid[i]) begin
            if (k < 32'(space)) begin
               slot_tag[k*TAG_WIDTH +: TAG_WIDTH] = RB_Tag[i*TAG_WIDTH +: TAG_WIDTH];
               slot_we[k] = 1'b1;
               k++;
            end else begin
               drop = 1'b1;
            end
         end
      end
      acc_cnt = CNT_W'(k);
   end

endmodule

// File: rtl/tag_freelist.sv
// Tomasulo tag free list: show-ahead pop, multi-port compacted return, sticky errors.
// Optional TAG_FREELIST_DUPCHK_EN adds in_use tracking and the dup_err output.
module tag_freelist
   import tag_pkg::*;
#(
   parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF,
   parameter int unsigned DEPTH     = 2**TAG_WIDTH,
   parameter int unsigned RET_PORTS = RET_PORTS_DEF
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [RET_PORTS*TAG_WIDTH-1:0] RB_Tag,
   input  logic [RET_PORTS-1:0]           RB_Tag_Valid,
   input  logic                           Rd_en,
   output logic [TAG_WIDTH-1:0]           Tag_Out,
   output logic                           tagFifo_full,
   output logic                           tagFifo_empty,
   output logic [clog2(DEPTH):0]          free_count,
   output logic                           ovf_err,
   output logic                           udf_err
`ifdef TAG_FREELIST_DUPCHK_EN
   ,
   output logic                           dup_err
`endif
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [TAG_WIDTH-1:0]           mem [DEPTH];
   logic [PW-1:0]                  rd_ptr, wr_ptr, space, acc_cnt;
   logic                           pop_acc, drop;
   logic [RET_PORTS-1:0]           ret_valid, slot_we;
   logic [RET_PORTS*TAG_WIDTH-1:0] slot_tag;

   assign Tag_Out       = mem[rd_ptr[AW-1:0]];
   assign tagFifo_empty = (rd_ptr == wr_ptr);
   assign tagFifo_full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
   assign pop_acc       = Rd_en & ~tagFifo_empty;
   // A same-cycle pop frees its slot for a return.
   assign space         = PW'(DEPTH) - free_count + PW'(pop_acc);

`ifdef TAG_FREELIST_DUPCHK_EN
   logic [DEPTH-1:0] in_use;
   logic             dup_drop;

   // Unallocated tags and repeats of an earlier port are filtered before compaction.
   always_comb begin
      logic ok;
      ret_valid = '0;
      dup_drop  = 1'b0;
      ok        = 1'b0;
      for (int unsigned i = 0; i < RET_PORTS; i++) begin
         if (RB_Tag_Valid[i]) begin
            ok = (32'(RB_Tag[i*TAG_WIDTH +: TAG_WIDTH]) < DEPTH) &&
                 in_use[AW'(RB_Tag[i*TAG_WIDTH +: TAG_WIDTH])];
            for (int unsigned j = 0; j < i; j++)
               if (RB_Tag_Valid[j] &&
                   RB_Tag[j*TAG_WIDTH +: TAG_WIDTH] == RB_Tag[i*TAG_WIDTH +: TAG_WIDTH])
                  ok = 1'b0;
            if (ok) ret_valid[i] = 1'b1;
            else    dup_drop     = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         in_use  <= '0;
         dup_err <= 1'b0;
      end else begin
         if (pop_acc) in_use[AW'(Tag_Out)] <= 1'b1;
         for (int unsigned k = 0; k < RET_PORTS; k++)
            if (slot_we[k]) in_use[AW'(slot_tag[k*TAG_WIDTH +: TAG_WIDTH])] <= 1'b0;
         if (dup_drop) dup_err <= 1'b1;
      end
   end
`else
   assign ret_valid = RB_Tag_Valid;
`endif

   tag_ret_compact #(
      .TAG_WIDTH (TAG_WIDTH),
      .RET_PORTS (RET_PORTS),
      .CNT_W     (PW)
   ) u_compact (
      .RB_Tag       (RB_Tag),
      .RB_Tag_Valid (ret_valid),
      .space        (space),
      .slot_tag     (slot_tag),
      .slot_we      (slot_we),
      .acc_cnt      (acc_cnt),
      .drop         (drop)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= TAG_WIDTH'(i);
         rd_ptr     <= '0;
         wr_ptr     <= PW'(DEPTH);
         free_count <= PW'(DEPTH);
         ovf_err    <= 1'b0;
         udf_err    <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < RET_PORTS; k++)
            if (slot_we[k]) mem[AW'(32'(wr_ptr) + k)] <= slot_tag[k*TAG_WIDTH +: TAG_WIDTH];
         if (pop_acc) rd_ptr <= rd_ptr + 1'b1;
         wr_ptr     <= wr_ptr + acc_cnt;
         free_count <= free_count - PW'(pop_acc) + acc_cnt;
         if (drop) ovf_err <= 1'b1;
         if (Rd_en && tagFifo_empty) udf_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tag_freelist.sv
// Self-checking bench for tag_freelist: directed scenarios plus random traffic
// against a queue-based free-list model.
module tb_tag_freelist;

   localparam int unsigned TW    = 5;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned RP    = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic [RP*TW-1:0]  RB_Tag;
   logic [RP-1:0]     RB_Tag_Valid;
   logic              Rd_en;
   logic [TW-1:0]     Tag_Out;
   logic              tagFifo_full, tagFifo_empty;
   logic [5:0]        free_count;
   logic              ovf_err, udf_err;
`ifdef TAG_FREELIST_DUPCHK_EN
   logic              dup_err;
`endif

   always #5 clock = ~clock;

   tag_freelist #(
      .TAG_WIDTH (TW),
      .DEPTH     (DEPTH),
      .RET_PORTS (RP)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .RB_Tag        (RB_Tag),
      .RB_Tag_Valid  (RB_Tag_Valid),
      .Rd_en         (Rd_en),
      .Tag_Out       (Tag_Out),
      .tagFifo_full  (tagFifo_full),
      .tagFifo_empty (tagFifo_empty),
      .free_count    (free_count),
      .ovf_err       (ovf_err),
      .udf_err       (udf_err)
`ifdef TAG_FREELIST_DUPCHK_EN
      ,
      .dup_err       (dup_err)
`endif
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   // reference model
   int unsigned fl[$];
   bit          m_ovf, m_udf, m_dup;
   bit          in_use[DEPTH];

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [RP*TW-1:0] pack(input int unsigned p0, input int unsigned p1);
      logic [TW-1:0] a, b;
      a = TW'(p0);
      b = TW'(p1);
      return {b, a};
   endfunction

   task automatic model_step(input bit rst, input bit rd, input logic [RP-1:0] v,
                             input logic [RP*TW-1:0] tags);
      int unsigned keep[$];
      bit          seen[DEPTH];
      bit          pop;
      int unsigned space, n, t, popped;
      if (rst) begin
         fl.delete();
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fl.push_back(i);
            in_use[i] = 1'b0;
         end
         m_ovf = 0; m_udf = 0; m_dup = 0;
         return;
      end
      foreach (seen[i]) seen[i] = 1'b0;
      for (int unsigned i = 0; i < RP; i++) begin
         if (v[i]) begin
            t = 32'(tags[i*TW +: TW]);
`ifdef TAG_FREELIST_DUPCHK_EN
            if (t < DEPTH && in_use[t] && !seen[t]) begin
               seen[t] = 1'b1;
               keep.push_back(t);
            end else m_dup = 1;
`else
            keep.push_back(t);
`endif
         end
      end
      pop = rd && fl.size() > 0;
      if (rd && fl.size() == 0) m_udf = 1;
      space = DEPTH - fl.size() + (pop ? 1 : 0);
      if (pop) begin
         popped = fl.pop_front();
         in_use[popped] = 1'b1;
      end
      n = 0;
      foreach (keep[i]) begin
         if (n < space) begin
            fl.push_back(keep[i]);
            in_use[keep[i]] = 1'b0;
            n++;
         end else m_ovf = 1;
      end
   endtask

   task automatic compare_all();
      check("empty", tagFifo_empty, fl.size() == 0);
      check("full",  tagFifo_full,  fl.size() == DEPTH);
      check("free_count", free_count, fl.size());
      if (fl.size() > 0) check("tag_out", Tag_Out, fl[0]);
      check("ovf_err", ovf_err, m_ovf);
      check("udf_err", udf_err, m_udf);
`ifdef TAG_FREELIST_DUPCHK_EN
      check("dup_err", dup_err, m_dup);
`endif
   endtask

   task automatic step(input bit rst, input bit rd, input logic [RP-1:0] v,
                       input logic [RP*TW-1:0] tags);
      reset        = rst;
      Rd_en        = rd;
      RB_Tag_Valid = v;
      RB_Tag       = tags;
      @(posedge clock);
      model_step(rst, rd, v, tags);
      @(negedge clock);
      compare_all();
   endtask

   task automatic pops(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(0, 1, '0, '0);
   endtask

   initial begin
      reset = 1'b1; Rd_en = 1'b0; RB_Tag_Valid = '0; RB_Tag = '0;
      @(negedge clock);

      // reset state and sequential drain
      step(1, 0, '0, '0);
      check("rst_full", tagFifo_full, 1);
      check("rst_empty", tagFifo_empty, 0);
      check("rst_tag", Tag_Out, 0);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         check("drain_tag", Tag_Out, i);
         step(0, 1, '0, '0);
      end
      check("drain_empty", tagFifo_empty, 1);
      check("drain_count", free_count, 0);
      check("drain_udf", udf_err, 0);

      // underflow, then return into empty list
      step(0, 1, '0, '0);
      check("udf_set", udf_err, 1);
      step(0, 0, 2'b01, pack(7, 0));
      check("ret7_tag", Tag_Out, 7);
      check("ret7_count", free_count, 1);

      // two-port return ordering
      step(1, 0, '0, '0);
      pops(4);
      step(0, 0, 2'b11, pack(1, 3));
      check("two_ret_count", free_count, 30);
      pops(28);
      check("order_first", Tag_Out, 1);
      step(0, 1, '0, '0);
      check("order_second", Tag_Out, 3);

      // full with pop and two returns
      step(1, 0, '0, '0);
      step(0, 1, 2'b11, pack(5, 6));
`ifndef TAG_FREELIST_DUPCHK_EN
      check("full_ovf", ovf_err, 1);
      check("full_count", free_count, 32);
`endif

      // mid-stream reset
      step(1, 0, '0, '0);
      pops(10);
      step(0, 0, 2'b11, pack(2, 4));
      step(0, 1, 2'b01, pack(8, 0));
      pops(2);
      step(1, 1, 2'b11, pack(3, 5));
      check("mid_rst_count", free_count, 32);
      check("mid_rst_tag", Tag_Out, 0);
      check("mid_rst_ovf", ovf_err, 0);
      check("mid_rst_udf", udf_err, 0);
      step(0, 1, '0, '0);
      check("restart_tag", Tag_Out, 1);

`ifdef TAG_FREELIST_DUPCHK_EN
      step(1, 0, '0, '0);
      step(0, 1, '0, '0);
      step(0, 0, 2'b11, pack(0, 0));
      check("dup_same_cycle", dup_err, 1);
      check("dup_count", free_count, 32);
      step(0, 0, 2'b01, pack(9, 0));
      check("never_alloc_count", free_count, 32);
`endif

      // random traffic
      step(1, 0, '0, '0);
      for (int unsigned c = 0; c < 3000; c++) begin
         bit rst, rd;
         rst = ($urandom_range(0, 199) == 0);
         rd  = ($urandom_range(0, 99) < ((c < 1500) ? 80 : 40));
         step(rst, rd, RP'($urandom), pack($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
